// File: rtl/sampler_pkg.sv
// Shared sample-rate divider constants and helpers.
package sampler_pkg;

  localparam int unsigned SAMPLER_WIDTH     = 32;
  localparam int unsigned SAMPLER_DIV_W     = 24;
  localparam int unsigned SAMPLER_OVR_CNT_W = 16;

  // Saturating increment for the dropped-sample counter.
  function automatic logic [SAMPLER_OVR_CNT_W-1:0] sat_inc(
    input logic [SAMPLER_OVR_CNT_W-1:0] val
  );
    return (val == '1) ? val : val + SAMPLER_OVR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sample_rate_divider_if.sv
// Sample stream interface: raw input samples plus valid/ready forwarded output.
interface sample_rate_divider_if
  import sampler_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLER_WIDTH
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  // Environment side: supplies samples and consumes the forwarded stream.
  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid
  );

  // Divider side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid
  );

endinterface

// File: rtl/sample_hold.sv
// Single-entry valid/ready register slice; a sample arriving while full and stalled is dropped.
module sample_hold
  import sampler_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLER_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             drop
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             accept;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    // Slot is free if empty or being drained this very cycle.
    accept  = !valid_q || out_ready;
    if (in_valid && accept) begin
      data_d  = in_data;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    drop = in_valid && !accept;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/sample_rate_divider.sv
// Forwards one of every div+1 offered samples; stalls drop samples and set sticky overrun.
// Optional dropped-sample counter: define SAMPLER_OVERRUN_CNT_EN.
module sample_rate_divider
  import sampler_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLER_WIDTH,
  parameter int unsigned DIV_W = SAMPLER_DIV_W
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         run,
  input  logic [DIV_W-1:0]             cfg_div,
  input  logic                         cfg_load,
  sample_rate_divider_if.slave         bus,
  output logic                         overrun
`ifdef SAMPLER_OVERRUN_CNT_EN
  ,
  output logic [SAMPLER_OVR_CNT_W-1:0] overrun_cnt
`endif
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic             sel;
  logic             drop;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    sel   = 1'b0;
    // Load wins over a same-cycle sample, which is discarded without counting.
    if (cfg_load) begin
      div_d = cfg_div;
      cnt_d = '0;
    end else if (!run) begin
      cnt_d = '0;
    end else if (bus.in_valid) begin
      if (cnt_q == '0) begin
        sel   = 1'b1;
        cnt_d = div_q;
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end
    overrun_d = cfg_load ? 1'b0 : (overrun_q || drop);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;

  sample_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (bus.in_data),
    .in_valid  (sel),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .drop      (drop)
  );

`ifdef SAMPLER_OVERRUN_CNT_EN
  logic [SAMPLER_OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (cfg_load) begin
      ovr_cnt_d = '0;
    end else if (drop) begin
      ovr_cnt_d = sat_inc(ovr_cnt_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ovr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_sample_rate_divider.sv
// Directed bench for sample_rate_divider; checks counter port when SAMPLER_OVERRUN_CNT_EN is set.
module tb_sample_rate_divider;
  import sampler_pkg::*;

  logic                     clock;
  logic                     reset_n;
  logic                     run;
  logic [SAMPLER_DIV_W-1:0] cfg_div;
  logic                     cfg_load;
  logic                     overrun;
`ifdef SAMPLER_OVERRUN_CNT_EN
  logic [SAMPLER_OVR_CNT_W-1:0] overrun_cnt;
`endif

  int n_cmp;
  int n_err;

  sample_rate_divider_if #(.WIDTH(32)) bus ();

  sample_rate_divider #(
    .WIDTH (32),
    .DIV_W (SAMPLER_DIV_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .cfg_div     (cfg_div),
    .cfg_load    (cfg_load),
    .bus         (bus),
    .overrun     (overrun)
`ifdef SAMPLER_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then settle before sampling outputs.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
`ifdef SAMPLER_OVERRUN_CNT_EN
    chk(tag, 32'(overrun_cnt), exp);
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n      = 1'b0;
    run          = 1'b0;
    cfg_div      = '0;
    cfg_load     = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk_cnt("rst_cnt", 32'd0);

    // Pass-through, one sample per clock.
    reset_n  = 1'b1;
    cfg_div  = 24'd0;
    cfg_load = 1'b1;
    step();
    cfg_load      = 1'b0;
    run           = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_data = 32'(i);
      step();
      chk("pt_valid", 32'(bus.out_valid), 32'd1);
      chk("pt_data", bus.out_data, 32'(i));
    end
    bus.in_valid = 1'b0;
    step();
    chk("pt_drain", 32'(bus.out_valid), 32'd0);
    chk("pt_overrun", 32'(overrun), 32'd0);

    // Divide by 4, continuous input: 0, 4, 8 forwarded.
    cfg_div  = 24'd3;
    cfg_load = 1'b1;
    step();
    cfg_load     = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_data = 32'(i);
      step();
      chk("d4_valid", 32'(bus.out_valid), (i % 4 == 0) ? 32'd1 : 32'd0);
      if (i % 4 == 0) chk("d4_data", bus.out_data, 32'(i));
    end

    // Divide by 4 with in_valid toggling: every 4th valid sample (i = 0, 8).
    cfg_load     = 1'b1;
    bus.in_valid = 1'b0;
    step();
    cfg_load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = 32'(100 + i);
      step();
      chk("tog_valid", 32'(bus.out_valid), (i == 0 || i == 8) ? 32'd1 : 32'd0);
      if (i == 0 || i == 8) chk("tog_data", bus.out_data, 32'(100 + i));
    end

    // Stalled consumer: 10 held, 11 and 12 dropped.
    cfg_div      = 24'd0;
    cfg_load     = 1'b1;
    bus.in_valid = 1'b0;
    step();
    cfg_load      = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'd10;
    step();
    chk("st_data0", bus.out_data, 32'd10);
    chk("st_ovr0", 32'(overrun), 32'd0);
    bus.in_data = 32'd11;
    step();
    chk("st_data1", bus.out_data, 32'd10);
    chk("st_ovr1", 32'(overrun), 32'd1);
    chk_cnt("st_cnt1", 32'd1);
    bus.in_data = 32'd12;
    step();
    chk("st_data2", bus.out_data, 32'd10);
    chk("st_valid2", 32'(bus.out_valid), 32'd1);
    chk_cnt("st_cnt2", 32'd2);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("st_deliver", bus.out_data, 32'd10);
    step();
    chk("st_drained", 32'(bus.out_valid), 32'd0);
    chk("st_ovr_sticky", 32'(overrun), 32'd1);

    // Load alongside sample 5: 5 discarded, 6 forwarded, then 9.
    cfg_div      = 24'd2;
    cfg_load     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd5;
    step();
    chk("ld_discard", 32'(bus.out_valid), 32'd0);
    chk("ld_ovr_clr", 32'(overrun), 32'd0);
    chk_cnt("ld_cnt_clr", 32'd0);
    cfg_load = 1'b0;
    for (int i = 6; i <= 9; i++) begin
      bus.in_data = 32'(i);
      step();
      chk("ld_valid", 32'(bus.out_valid), (i == 6 || i == 9) ? 32'd1 : 32'd0);
      if (i == 6 || i == 9) chk("ld_data", bus.out_data, 32'(i));
    end

    // Mid-stream reset while holding a sample and flagged overrun.
    cfg_div       = 24'd0;
    cfg_load      = 1'b1;
    bus.in_valid  = 1'b0;
    step();
    cfg_load      = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h55;
    step();
    bus.in_data = 32'h56;
    step();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_ovr", 32'(overrun), 32'd1);
    reset_n  = 1'b0;
    cfg_div  = 24'd7;
    cfg_load = 1'b1;
    step();
    chk("mrst_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_data", bus.out_data, 32'd0);
    chk("mrst_ovr", 32'(overrun), 32'd0);
    chk_cnt("mrst_cnt", 32'd0);
    reset_n       = 1'b1;
    cfg_load      = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_data   = 32'hAA;
    step();
    chk("post_valid0", 32'(bus.out_valid), 32'd1);
    chk("post_data0", bus.out_data, 32'hAA);
    bus.in_data = 32'hAB;
    step();
    chk("post_data1", bus.out_data, 32'hAB);

    // run low: nothing selected, slot drains.
    run         = 1'b0;
    bus.in_data = 32'hCC;
    step();
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
    run = 1'b1;
    step();
    chk("resume_data", bus.out_data, 32'hCC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sample_rate_divider.md
# sample_rate_divider

Sample-rate divider in the core clock domain, directly downstream of the clock-doubling PLL stage. It takes the raw input sample stream (up to one sample per core clock) and forwards one of every `div+1` valid samples. Forwarding is through a single-register valid/ready output to the capture/trigger logic. Output stalls are flagged as overruns rather than back-pressuring the input, because input pins cannot be stalled.

## Interface
- `WIDTH`, 32, sample width in bits
- `DIV_W`, 24, divider register width

- `clock`  in  1  core clock (doubled-rate PLL output); all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `run`  in  1  sampling enable; low holds the divider idle
- `cfg_div`  in  DIV_W  divide value; forward 1 of every `cfg_div+1` valid inputs
- `cfg_load`  in  1  one-cycle strobe; latches `cfg_div`, restarts the divider, clears overrun
- `in_data`  in  WIDTH  raw sample
- `in_valid`  in  1  `in_data` is valid this cycle
- `out_data`  out  WIDTH  forwarded sample
- `out_valid`  out  1  `out_data` is held for the consumer
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`
- `overrun`  out  1  sticky: a selected sample was dropped
- `overrun_cnt`  out  16  dropped-sample count (present only with the macro below)

## Operation
- Registers:
  - `div_reg` (DIV_W)
  - `cnt` (DIV_W, down-counter)
  - output register `out_data`/`out_valid`
  - `overrun`
- Select rule, when `run=1` and `in_valid=1` (the input is "offered"):
  - if `cnt==0`: the sample is selected and `cnt<=div_reg`
  - else: `cnt<=cnt-1`
- Cycles with `in_valid=0` do not advance `cnt`.
- `run=0`: `cnt<=0`; no sample is selected; the output register still drains normally.
- `cfg_load=1`: `div_reg<=cfg_div`, `cnt<=0`, `overrun<=0`.
  - `cfg_load` has priority: a sample offered in the same cycle is discarded and does not advance the count.
  - The first offered sample after the load is selected.
- `div_reg=0` is pass-through: every offered sample is selected.
- `div_reg=2^DIV_W-1` is legal; there is no wrap issue because `cnt` reloads from `div_reg`.
- Output register, handling a selected sample:
  - If the slot is empty, or is being consumed this cycle (`out_valid && out_ready`): load the sample and set `out_valid=1`.
  - Otherwise (`out_valid && !out_ready`): drop the sample, set `overrun<=1`, and leave `out_data` unchanged.
- If the slot is consumed and no sample is selected in the same cycle: `out_valid<=0`.
- While `out_valid=1` and `out_ready=0`, `out_data` is stable.

## Timing
- Reset (`reset_n=0` at a clock edge):
  - `out_valid=0`, `out_data=0`, `overrun=0`, `overrun_cnt=0`
  - `div_reg=0`, `cnt=0`
  - Reset overrides `cfg_load` and any in-flight sample; a held sample is lost.
- Latency: a sample selected at edge N shows `out_valid=1` with its `out_data` after edge N (one cycle).
- Throughput: one sample per clock when `div_reg=0` and `out_ready=1` continuously.
- `cfg_load` takes effect at the edge it is sampled; `div_reg` is used from the following cycle.
- `cfg_load` does not flush the output register: a held sample stays until consumed.

## Configuration
- `SAMPLER_OVERRUN_CNT_EN` defined:
  - `overrun_cnt` increments on every dropped sample, saturating at 16'hFFFF.
  - It is cleared by `cfg_load` and by reset.
- Not defined:
  - The `overrun_cnt` port is absent and no counter logic exists.
  - The sticky `overrun` bit still exists.

## Structure
- Shared package `sampler_pkg`:
  - `SAMPLER_DIV_W` (24)
  - `SAMPLER_OVR_CNT_W` (16)
  - Default `WIDTH`
- One sub-module, `sample_hold`: a single-entry valid/ready register slice with a drop-on-full indication.
  - The divider instantiates it.
  - Its drop pulse feeds `overrun` and `overrun_cnt`.

## Test plan
- Reset then `cfg_div=0` and `cfg_load`; `run=1`, `out_ready=1`, `in_data` = 1,2,3,4 on consecutive cycles -> `out_data` = 1,2,3,4, each one cycle later; `overrun=0`.
- `cfg_div=3`, `in_data` = 0..11 all valid -> outputs 0,4,8 only.
- Same setup with `in_valid` toggling 1,0,1,0 -> outputs every 4th *valid* sample.
- `cfg_div=0`, `out_ready=0` for 3 cycles with samples 10,11,12 -> `out_data` holds 10; `overrun=1`; `overrun_cnt=2` (macro on); releasing `out_ready` delivers 10.
- `cfg_div=2`, `cfg_load` asserted alongside sample 5 -> 5 is discarded; the next valid sample 6 is output; `overrun` is cleared.
- Mid-stream `reset_n=0` for 1 cycle while `out_valid=1` -> next cycle `out_valid=0` and all counters are zero; after release, pass-through behaviour resumes from the next offered sample.
